// File: rtl/turn_signal_scheduler_if.sv
// Bundles the driver-switch requests and lamp/status outputs of turn_signal_scheduler.
// master = switch decoder / observer side, slave = the scheduler itself.
interface turn_signal_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             left_req;
  logic             right_req;
  logic             hazard_req;
  logic             off;
  logic             lane_mode;
  logic             o_left_led;
  logic             o_right_led;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_blink_cnt;
  logic             o_done;

  modport master (
    output left_req, right_req, hazard_req, off, lane_mode,
    input  o_left_led, o_right_led, o_state, o_blink_cnt, o_done
  );

  modport slave (
    input  left_req, right_req, hazard_req, off, lane_mode,
    output o_left_led, o_right_led, o_state, o_blink_cnt, o_done
  );
endinterface

// File: rtl/turn_signal_scheduler.sv
// Turn-signal mode arbiter with internal blink prescaler and lane-change auto-cancel.
// Optional macro HAZARD_MEMORY_EN: hazard exit by hazard_req resumes the interrupted direction.
module turn_signal_scheduler #(
  parameter int CLK_PER_HALF = 4,
  parameter int LANE_BLINKS  = 3,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  turn_signal_scheduler_if.slave  bus
);

  localparam int PH_W = (CLK_PER_HALF > 1) ? $clog2(CLK_PER_HALF) : 1;
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(CLK_PER_HALF - 1);
  localparam logic [CNT_W-1:0] LANE_N  = CNT_W'(LANE_BLINKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEFT   = 3'd1,
    S_RIGHT  = 3'd2,
    S_HAZARD = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             phase_on_q, phase_on_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic             lane_q, lane_d;
`ifdef HAZARD_MEMORY_EN
  logic [1:0]       mem_dir_q, mem_dir_d;   // 0 = none, 1 = left, 2 = right
  logic             mem_lane_q, mem_lane_d;
`endif

  logic   enter;
  state_t enter_state;
  logic   enter_lane;
  logic   advance;
  logic   one_dir;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    phase_on_d  = phase_on_q;
    blink_d     = blink_q;
    lane_d      = lane_q;
`ifdef HAZARD_MEMORY_EN
    mem_dir_d   = mem_dir_q;
    mem_lane_d  = mem_lane_q;
`endif
    enter       = 1'b0;
    enter_state = S_IDLE;
    enter_lane  = 1'b0;
    advance     = 1'b0;
    one_dir     = bus.left_req ^ bus.right_req;

    case (state_q)
      S_IDLE: begin
        if (bus.hazard_req) begin
          enter       = 1'b1;
          enter_state = S_HAZARD;
`ifdef HAZARD_MEMORY_EN
          mem_dir_d   = 2'd0;
`endif
        end else if (!bus.off && one_dir) begin
          enter       = 1'b1;
          enter_state = bus.left_req ? S_LEFT : S_RIGHT;
          enter_lane  = bus.lane_mode;
        end
      end
      S_LEFT, S_RIGHT: begin
        if (bus.hazard_req) begin
          enter       = 1'b1;
          enter_state = S_HAZARD;
`ifdef HAZARD_MEMORY_EN
          mem_dir_d   = (state_q == S_LEFT) ? 2'd1 : 2'd2;
          mem_lane_d  = lane_q;
`endif
        end else if (bus.off) begin
          state_d = S_FINISH;
        end else if (one_dir && ((state_q == S_LEFT) ? bus.right_req : bus.left_req)) begin
          enter       = 1'b1;
          enter_state = bus.left_req ? S_LEFT : S_RIGHT;
          enter_lane  = bus.lane_mode;
        end else begin
          advance = 1'b1;
        end
      end
      S_HAZARD: begin
        if (bus.hazard_req) begin
          state_d = S_FINISH;
`ifdef HAZARD_MEMORY_EN
          if (mem_dir_q != 2'd0) begin
            enter       = 1'b1;
            enter_state = (mem_dir_q == 2'd1) ? S_LEFT : S_RIGHT;
            enter_lane  = mem_lane_q;
          end
`endif
        end else if (bus.off) begin
          state_d = S_FINISH;
        end else begin
          advance = 1'b1;
        end
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        phase_d    = '0;
        phase_on_d = 1'b1;
        blink_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering an active mode restarts the timebase; otherwise the prescaler runs on.
    if (enter) begin
      state_d    = enter_state;
      phase_d    = '0;
      phase_on_d = 1'b1;
      blink_d    = '0;
      lane_d     = enter_lane;
    end else if (advance) begin
      if (phase_q == PH_MAX) begin
        phase_d    = '0;
        phase_on_d = !phase_on_q;
        if (!phase_on_q) begin
          blink_d = sat_inc(blink_q);
          if (lane_q && blink_d == LANE_N) state_d = S_FINISH;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      phase_on_q <= 1'b1;
      blink_q    <= '0;
      lane_q     <= 1'b0;
`ifdef HAZARD_MEMORY_EN
      mem_dir_q  <= 2'd0;
      mem_lane_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      phase_on_q <= phase_on_d;
      blink_q    <= blink_d;
      lane_q     <= lane_d;
`ifdef HAZARD_MEMORY_EN
      mem_dir_q  <= mem_dir_d;
      mem_lane_q <= mem_lane_d;
`endif
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_left_led  = phase_on_q & ((state_q == S_LEFT)  | (state_q == S_HAZARD));
  assign bus.o_right_led = phase_on_q & ((state_q == S_RIGHT) | (state_q == S_HAZARD));
  assign bus.o_blink_cnt = blink_q;
  assign bus.o_done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Directed bench for turn_signal_scheduler: a time-since-entry mode model checked every cycle,
// plus hand-computed expectations at the scenario checkpoints.
module tb_turn_signal_scheduler;

  localparam int CPH = 4;
  localparam int LB  = 3;
  localparam int CW  = 8;
  localparam int PER = 2 * CPH;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  turn_signal_scheduler_if #(.CNT_W(CW)) bus ();

  turn_signal_scheduler #(
    .CLK_PER_HALF(CPH),
    .LANE_BLINKS (LB),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: mode (0 idle,1 left,2 right,3 hazard,4 finish), cycles since entry, lane flag.
  int m_mode = 0;
  int m_t    = 0;
  int m_lane = 0;
  int m_fin  = 0;
`ifdef HAZARD_MEMORY_EN
  int m_mem_dir  = 0;
  int m_mem_lane = 0;
`endif

  function automatic int blinks_of(input int t);
    return (t / PER > SAT) ? SAT : t / PER;
  endfunction

  function automatic bit active(input int md);
    return md == 1 || md == 2 || md == 3;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int nm, nt, nl, nf, cur;
    bit one;
    if (reset) begin
      m_mode <= 0; m_t <= 0; m_lane <= 0; m_fin <= 0;
`ifdef HAZARD_MEMORY_EN
      m_mem_dir <= 0; m_mem_lane <= 0;
`endif
    end else begin
      nm = m_mode; nt = m_t; nl = m_lane; nf = m_fin;
      cur = blinks_of(m_t);
      one = bus.left_req ^ bus.right_req;
      case (m_mode)
        0: begin
          if (bus.hazard_req) begin
            nm = 3; nt = 0; nl = 0;
`ifdef HAZARD_MEMORY_EN
            m_mem_dir <= 0;
`endif
          end else if (!bus.off && one) begin
            nm = bus.left_req ? 1 : 2; nt = 0; nl = int'(bus.lane_mode);
          end
        end
        1, 2: begin
          if (bus.hazard_req) begin
`ifdef HAZARD_MEMORY_EN
            m_mem_dir <= m_mode; m_mem_lane <= m_lane;
`endif
            nm = 3; nt = 0; nl = 0;
          end else if (bus.off) begin
            nm = 4; nf = cur;
          end else if (one && ((m_mode == 1) ? bus.right_req : bus.left_req)) begin
            nm = 3 - m_mode; nt = 0; nl = int'(bus.lane_mode);
          end else begin
            nt = m_t + 1;
            if (m_lane != 0 && nt % PER == 0 && nt / PER == LB) begin
              nm = 4; nf = LB;
            end
          end
        end
        3: begin
          if (bus.hazard_req) begin
            nm = 4; nf = cur;
`ifdef HAZARD_MEMORY_EN
            if (m_mem_dir != 0) begin
              nm = m_mem_dir; nt = 0; nl = m_mem_lane;
            end
`endif
          end else if (bus.off) begin
            nm = 4; nf = cur;
          end else begin
            nt = m_t + 1;
          end
        end
        default: begin
          nm = 0; nt = 0;
        end
      endcase
      m_mode <= nm; m_t <= nt; m_lane <= nl; m_fin <= nf;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_state", 32'(bus.o_state), 32'(m_mode));
      check("mdl_left",  32'(bus.o_left_led),
            32'(active(m_mode) && (m_mode != 2) && (m_t % PER) < CPH));
      check("mdl_right", 32'(bus.o_right_led),
            32'(active(m_mode) && (m_mode != 1) && (m_t % PER) < CPH));
      check("mdl_blink", 32'(bus.o_blink_cnt),
            32'(active(m_mode) ? blinks_of(m_t) : (m_mode == 4) ? m_fin : 0));
      check("mdl_done",  32'(bus.o_done), 32'(m_mode == 4));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic l, input logic r, input logic h, input logic o);
    bus.left_req = l; bus.right_req = r; bus.hazard_req = h; bus.off = o;
    @(negedge clk);
    bus.left_req = 0; bus.right_req = 0; bus.hazard_req = 0; bus.off = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    int acc, accr, n;
    bus.left_req = 0; bus.right_req = 0; bus.hazard_req = 0; bus.off = 0; bus.lane_mode = 0;
    reset = 1;
    repeat (2) tick();
    check("rst_state", 32'(bus.o_state), 0);
    check("rst_leds",  32'({bus.o_left_led, bus.o_right_led}), 0);
    check("rst_blink", 32'(bus.o_blink_cnt), 0);
    check("rst_done",  32'(bus.o_done), 0);
    reset = 0;
    chk_en = 1;
    tick();

    // Plain left: 1111 0000 pattern, blinks counted at cycles 8 and 16
    pulse(1, 0, 0, 0);
    pat = '0; accr = 0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick();
      if (i < 16) pat = {pat[14:0], bus.o_left_led};
      accr += int'(bus.o_right_led);
      if (i == 0)  check("t1_state", 32'(bus.o_state), 1);
      if (i == 8)  check("t1_blink8", 32'(bus.o_blink_cnt), 1);
      if (i == 16) check("t1_blink16", 32'(bus.o_blink_cnt), 2);
    end
    check("t1_pattern", 32'(pat), 32'h0000F0F0);
    check("t1_right_off", 32'(accr), 0);

    // Opposite direction restarts phase and count
    pulse(0, 1, 0, 0);
    check("t3_state", 32'(bus.o_state), 2);
    check("t3_blink", 32'(bus.o_blink_cnt), 0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      if (i < 4) acc += int'(bus.o_right_led);
      else check("t3_fifth_off", 32'(bus.o_right_led), 0);
    end
    check("t3_on4", 32'(acc), 4);
    pulse(0, 0, 0, 1);
    check("t3_finish", 32'(bus.o_state), 4);
    tick();
    check("t3_idle", 32'(bus.o_state), 0);

    // Lane change: exactly three blinks then FINISH
    bus.lane_mode = 1;
    pulse(0, 1, 0, 0);
    bus.lane_mode = 0;
    n = 0;
    while (bus.o_state == 3'd2 && n < 40) begin
      n++;
      tick();
    end
    check("t2_cycles", 32'(n), 24);
    check("t2_finish", 32'(bus.o_state), 4);
    check("t2_done", 32'(bus.o_done), 1);
    check("t2_blink_fin", 32'(bus.o_blink_cnt), 3);
    tick();
    check("t2_idle", 32'(bus.o_state), 0);
    check("t2_blink_idle", 32'(bus.o_blink_cnt), 0);

    // Hazard outranks left in the same cycle; both lamps in phase
    pulse(1, 0, 1, 0);
    check("t4_state", 32'(bus.o_state), 3);
    acc = 0; accr = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      acc  += int'(bus.o_left_led);
      accr += int'(bus.o_left_led != bus.o_right_led);
    end
    check("t4_on4", 32'(acc), 4);
    check("t4_inphase", 32'(accr), 0);
    pulse(0, 0, 1, 0);
    check("t4_finish", 32'(bus.o_state), 4);
    tick();
    check("t4_idle", 32'(bus.o_state), 0);

    // Ignored requests in IDLE
    pulse(1, 1, 0, 0);
    check("t5_both_state", 32'(bus.o_state), 0);
    check("t5_both_leds", 32'({bus.o_left_led, bus.o_right_led}), 0);
    pulse(0, 0, 0, 1);
    check("t5_off_state", 32'(bus.o_state), 0);

    // Hazard interrupting LEFT, then hazard again
    pulse(1, 0, 0, 0);
    repeat (3) tick();
    pulse(0, 0, 1, 0);
    check("t7_hazard", 32'(bus.o_state), 3);
    tick();
    pulse(0, 0, 1, 0);
`ifdef HAZARD_MEMORY_EN
    check("t7_resume_state", 32'(bus.o_state), 1);
    check("t7_resume_blink", 32'(bus.o_blink_cnt), 0);
    check("t7_resume_led", 32'(bus.o_left_led), 1);
    pulse(0, 0, 0, 1);
`else
    check("t7_exit_state", 32'(bus.o_state), 4);
`endif
    tick();
    check("t7_idle", 32'(bus.o_state), 0);

    // Asynchronous reset during RIGHT on-phase
    pulse(0, 1, 0, 0);
    tick();
    check("t6_pre_led", 32'(bus.o_right_led), 1);
    #1 reset = 1;
    #1;
    check("t6_async_state", 32'(bus.o_state), 0);
    check("t6_async_led", 32'(bus.o_right_led), 0);
    tick();
    reset = 0;
    repeat (2) tick();
    check("t6_after_state", 32'(bus.o_state), 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/turn_signal_scheduler.md
Name: turn_signal_scheduler

Overview:
- Sequences the car turn-signal lamps: arbitrates left, right, hazard and off requests into one active mode.
- Generates the blink timebase internally from a clock-cycle prescaler, replacing clock-gated LED drive.
- Auto-cancels lane-change blinks after a fixed count.
- Sits between the driver switch decoder and the lamp drivers; one instance per vehicle.

Parameters:
- CLK_PER_HALF, 4: clk cycles per LED on-phase and per off-phase (blink period = 2*CLK_PER_HALF); must be >= 1.
- LANE_BLINKS, 3: full blinks before auto-cancel in lane-change mode; must be >= 1 and <= 2^CNT_W-1.
- CNT_W, 8: width of the blink counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- left_req  input  1  one-cycle pulse: request left signal.
- right_req  input  1  one-cycle pulse: request right signal.
- hazard_req  input  1  one-cycle pulse: toggle hazard.
- off  input  1  one-cycle pulse: cancel active signal.
- lane_mode  input  1  level; sampled when a direction is accepted; 1 = auto-cancel after LANE_BLINKS.
- o_left_led  output  1  left lamp drive.
- o_right_led  output  1  right lamp drive.
- o_state  output  3  current state encoding.
- o_blink_cnt  output  CNT_W  completed blinks in the current mode.
- o_done  output  1  high for exactly the one FINISH cycle.

Behaviour:
- States and encodings: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3, FINISH=4. All registers are reset asynchronously.
- Reset values: state=IDLE, phase counter=0, phase_on=1, blink_cnt=0, lane latch=0. All outputs are 0.
- Request priority within a cycle: hazard_req > off > direction request.
- IDLE transitions:
  - left_req alone -> LEFT.
  - right_req alone -> RIGHT.
  - left_req and right_req together -> ignored, stay IDLE.
  - hazard_req -> HAZARD.
  - off -> ignored.
- LEFT/RIGHT transitions:
  - hazard_req -> HAZARD.
  - off -> FINISH.
  - Opposite-direction request -> the other direction, with phase and blink_cnt restarted and lane_mode re-latched.
  - Same-direction request -> ignored.
  - Both direction requests together -> ignored.
- HAZARD transitions:
  - hazard_req -> FINISH.
  - off -> FINISH.
  - Direction requests -> ignored.
- FINISH: unconditionally -> IDLE after one cycle; all requests are ignored.
- Entry into LEFT, RIGHT or HAZARD: phase counter=0, phase_on=1, blink_cnt=0. lane_mode is latched on direction entry; the latch is cleared on hazard entry.
- Phase counter: counts 0..CLK_PER_HALF-1 in active states. On reaching CLK_PER_HALF-1 it wraps to 0 and phase_on toggles.
- Blink count: when phase_on goes 0->1 (end of an off-phase), blink_cnt increments and saturates at 2^CNT_W-1.
- Lane-change auto-cancel: if the lane latch is set and the increment makes blink_cnt == LANE_BLINKS, the next state is FINISH instead of continuing.
- LED decode (combinational from registered state and phase_on):
  - o_left_led = phase_on & (state==LEFT | state==HAZARD).
  - o_right_led = phase_on & (state==RIGHT | state==HAZARD).
  - LEDs are 0 in IDLE and FINISH.
- Latency: a request pulse sampled at edge k gives the new state and lit LED in cycle k+1, lasting CLK_PER_HALF cycles.
- o_blink_cnt holds its last value through FINISH and clears on the return to IDLE.
- Reset asserted mid-blink forces IDLE with LEDs off immediately, independent of clk.

Optional Feature:
- Macro: HAZARD_MEMORY_EN.
- Defined:
  - On HAZARD entry from LEFT or RIGHT, the direction and its lane latch are stored.
  - Exiting HAZARD by hazard_req returns to the stored direction with phase and count restarted.
  - Exiting by off still goes to FINISH.
  - Hazard entered from IDLE returns through FINISH.
- Undefined: every HAZARD exit goes to FINISH, and no storage is implemented.

Test Plan:
- CLK_PER_HALF=4, lane_mode=0, left_req pulse -> o_state=1; o_left_led pattern 1111 0000 repeating; o_blink_cnt=1 after cycle 8, 2 after cycle 16; o_right_led stays 0.
- lane_mode=1, right_req, LANE_BLINKS=3 -> exactly 3 blinks (24 cycles), then FINISH for one cycle with o_done=1, then IDLE with o_blink_cnt=0.
- In LEFT with o_blink_cnt=2, right_req -> RIGHT next cycle; phase and count restart at 0; o_right_led high for 4 cycles.
- left_req and hazard_req in the same cycle from IDLE -> HAZARD; both LEDs blink in phase; second hazard_req -> FINISH, then IDLE.
- left_req and right_req together in IDLE -> remain IDLE, LEDs 0. off in IDLE -> no change.
- Reset asserted in the LED-on phase of RIGHT -> o_right_led=0 and o_state=0 without waiting for a clk edge. With HAZARD_MEMORY_EN: LEFT -> hazard -> hazard returns to LEFT with o_blink_cnt=0.
